wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the W-stage result (ResultW, the output of the writeback result mux) and a multi-cycle unit (divider or other long-latency FU).
- The pipeline always has priority. Multi-cycle results queue in a small FIFO and drain into free writeback slots.
- A starvation guard requests a W-stage bubble from the hazard unit.
- A pending-rd lookup lets the hazard unit hold dependent instructions.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8: consecutive blocked cycles before a bubble is requested; at least 1.
- DATA_W, 32: result width.
- ADDR_W, 5: register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- RegWriteW  in  1  W-stage write enable
- RdW  in  ADDR_W  W-stage destination
- ResultW  in  DATA_W  W-stage result (from the result mux)
- McValid  in  1  multi-cycle result valid
- McRd  in  ADDR_W  multi-cycle destination
- McData  in  DATA_W  multi-cycle result
- McReady  out  1  arbiter can accept a multi-cycle result
- RfWe  out  1  register-file write enable
- RfWa  out  ADDR_W  register-file write address
- RfWd  out  DATA_W  register-file write data
- StallReq  out  1  request to the hazard unit to bubble W next cycle
- CheckRd  in  ADDR_W  register queried by the hazard unit
- CheckHit  out  1  CheckRd has a pending write queued in the FIFO

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; starve counter 0; state IDLE.
  - RfWe=0, StallReq=0, CheckHit=0, McReady=1.
- Pipeline slot:
  - PipeWr = RegWriteW && RdW!=0.
  - A write with RdW==0 is discarded and the slot counts as free.
- Write port (combinational):
  - If PipeWr: RfWe=1, RfWa=RdW, RfWd=ResultW.
  - Else if FIFO non-empty: write the head entry and pop it at the clock edge.
  - Else RfWe=0.
- Push:
  - McReady = !full, from the registered count only. No push-on-full even if a pop occurs the same cycle.
  - Accept when McValid && McReady.
  - Entries with McRd==0 are accepted and dropped (not queued).
- Latency: a result accepted in cycle t with the FIFO empty is written at the earliest in t+1.
- Ordering:
  - FIFO entries drain strictly in order.
  - WAW between a pipeline write and a queued entry is prevented upstream via CheckHit. The arbiter never reorders or merges.
- CheckHit: 1 if any valid FIFO entry has rd==CheckRd and CheckRd!=0. Combinational; includes an entry being popped this cycle.
- FSM:
  - IDLE (FIFO empty) -> DRAIN on push.
  - DRAIN:
    - Starve counter increments each cycle FIFO is non-empty and PipeWr=1; clears on every pop.
    - counter==STARVE_LIMIT-1 while blocked -> FORCE.
    - Pop leaving FIFO empty -> IDLE.
  - FORCE:
    - StallReq=1 (Moore).
    - On pop: counter clears; go to IDLE if empty, else DRAIN.
    - StallReq is advisory: if the pipeline still writes, it still wins and FORCE holds.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Reset mid-operation: queued entries are lost; outputs go to reset values immediately.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, PipeWr=0 and McValid=1 with McRd!=0, the multi-cycle result writes the port in the same cycle and is not queued.
  - Latency is 0 cycles.
  - McReady is unchanged.
- Undefined: every accepted result passes through the FIFO; minimum latency 1 cycle.

Decomposition:
- Package wb_arb_pkg:
  - typedef wb_entry_t: struct {rd, data}.
  - enum wb_arb_state_t: IDLE, DRAIN, FORCE.
  - Localparam for the pointer width, $clog2(DEPTH).
- Sub-module wb_fifo:
  - Synchronous FIFO of wb_entry_t, DEPTH deep.
  - Outputs full/empty/head plus an entry-valid vector for the CheckHit compare.
- The arbiter holds the FSM, starve counter and port mux.

Test Plan:
- Idle pipeline (RegWriteW=0), McValid with McRd=5, McData=0x1234 in cycle 1 -> RfWe=1, RfWa=5, RfWd=0x1234 in cycle 2 (cycle 1 with BYPASS_EN). CheckHit(5)=1 in cycle 2 only.
- Pipeline writes every cycle; push 4 results -> McReady=0 after the 4th push. StallReq=1 from the 8th blocked cycle. First bubble pops the head; StallReq drops next cycle.
- RegWriteW=1, RdW=0, FIFO holds {rd=3, data=0xAA} -> the FIFO entry is written (RfWa=3) and the x0 write is discarded.
- FIFO full; same cycle pop and McValid=1 -> push is refused (McReady=0). Count goes 4->3; McReady=1 the next cycle.
- Push McRd=0 -> nothing queued and no write ever issued; CheckHit(0)=0.
- Assert rst asynchronously with 3 entries queued and StallReq=1 -> within the same cycle RfWe=0, StallReq=0, McReady=1. No queued write is issued after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the writeback port arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_PTR_W  = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FORCE
  } wb_arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending multi-cycle results; exposes every slot and its
// valid bit so the arbiter can search for pending destinations.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  last_o,
  output logic      [DEPTH-1:0] vld_o,
  output wb_entry_t [DEPTH-1:0] ents_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic      [PTR_W-1:0] wr_q, rd_q;
  logic      [CNT_W-1:0] cnt_q;
  logic      [DEPTH-1:0] vld_q;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CNT_W'(1));
  assign head_o  = mem_q[rd_q];
  assign vld_o   = vld_q;
  assign ents_o  = mem_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Push and pop never target the same slot: that needs both full and empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      mem_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + PTR_W'(1);
      end
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and a multi-cycle unit.
// Optional same-cycle bypass of an idle port: define WB_ARB_BYPASS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = WB_DEPTH,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned DATA_W       = WB_DATA_W,
  parameter int unsigned ADDR_W       = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              McValid,
  input  logic [ADDR_W-1:0] McRd,
  input  logic [DATA_W-1:0] McData,
  output logic              McReady,
  output logic              RfWe,
  output logic [ADDR_W-1:0] RfWa,
  output logic [DATA_W-1:0] RfWd,
  output logic              StallReq,
  input  logic [ADDR_W-1:0] CheckRd,
  output logic              CheckHit
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  if (DATA_W != WB_DATA_W || ADDR_W != WB_ADDR_W) begin : g_width_chk
    $error("wb_port_arbiter: DATA_W/ADDR_W must match wb_arb_pkg entry widths");
  end

  wb_arb_state_t         state_q, state_d;
  logic      [SW-1:0]    starve_q, starve_d;
  wb_entry_t             fifo_head, fifo_in;
  wb_entry_t [DEPTH-1:0] fifo_ents;
  logic      [DEPTH-1:0] fifo_vld;
  logic                  fifo_full, fifo_empty, fifo_last;
  logic                  pipe_wr, byp, push, pop, blocked, pop_to_empty;

  assign pipe_wr = RegWriteW && (RdW != '0);

`ifdef WB_ARB_BYPASS_EN
  assign byp = fifo_empty && !pipe_wr && McValid && (McRd != '0);
`else
  assign byp = 1'b0;
`endif

  assign McReady      = !fifo_full;
  assign push         = McValid && McReady && (McRd != '0) && !byp;
  assign pop          = !pipe_wr && !fifo_empty;
  assign blocked      = pipe_wr && !fifo_empty;
  assign pop_to_empty = pop && fifo_last && !push;
  assign fifo_in      = '{rd: McRd, data: McData};
  assign StallReq     = (state_q == FORCE);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (fifo_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last),
    .vld_o   (fifo_vld),
    .ents_o  (fifo_ents)
  );

  // Pipeline always wins; the queue head takes any slot the pipeline leaves free.
  always_comb begin
    RfWe = 1'b0;
    RfWa = '0;
    RfWd = '0;
    if (!rst) begin
      if (pipe_wr) begin
        RfWe = 1'b1;
        RfWa = RdW;
        RfWd = ResultW;
      end else if (!fifo_empty) begin
        RfWe = 1'b1;
        RfWa = fifo_head.rd;
        RfWd = fifo_head.data;
      end else if (byp) begin
        RfWe = 1'b1;
        RfWa = McRd;
        RfWd = McData;
      end
    end
  end

  always_comb begin
    CheckHit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_ents[i].rd == CheckRd)) CheckHit = 1'b1;
    end
    if (CheckRd == '0) CheckHit = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (push) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop) begin
          starve_d = '0;
          if (pop_to_empty) state_d = IDLE;
        end else if (blocked) begin
          starve_d = starve_q + SW'(1);
          if (starve_q == SW'(STARVE_LIMIT - 1)) state_d = FORCE;
        end
      end
      FORCE: begin
        // Bubble request is advisory; hold until the queue actually gets a slot.
        if (pop) begin
          starve_d = '0;
          state_d  = pop_to_empty ? IDLE : DRAIN;
        end
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: one task per scenario, inline checks.
module tb_wb_port_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          RegWriteW;
  logic [AW-1:0] RdW;
  logic [DW-1:0] ResultW;
  logic          McValid;
  logic [AW-1:0] McRd;
  logic [DW-1:0] McData;
  logic          McReady;
  logic          RfWe;
  logic [AW-1:0] RfWa;
  logic [DW-1:0] RfWd;
  logic          StallReq;
  logic [AW-1:0] CheckRd;
  logic          CheckHit;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .McValid   (McValid),
    .McRd      (McRd),
    .McData    (McData),
    .McReady   (McReady),
    .RfWe      (RfWe),
    .RfWa      (RfWa),
    .RfWd      (RfWd),
    .StallReq  (StallReq),
    .CheckRd   (CheckRd),
    .CheckHit  (CheckHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    McValid = 1'b0; McRd = '0; McData = '0; CheckRd = '0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (RfWe !== 1'b0)     begin errors++; $display("FAIL reset_we: got %0b want 0", RfWe); end
    checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", StallReq); end
    checks++; if (CheckHit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", CheckHit); end
    checks++; if (McReady !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %0b want 1", McReady); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic          exp_we0, exp_we1, exp_hit1;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    exp_wa = AW'(5);
    exp_wd = DW'(32'h1234);
`ifdef WB_ARB_BYPASS_EN
    exp_we0 = 1'b1; exp_we1 = 1'b0; exp_hit1 = 1'b0;
`else
    exp_we0 = 1'b0; exp_we1 = 1'b1; exp_hit1 = 1'b1;
`endif
    cyc();
    McValid = 1'b1; McRd = AW'(5); McData = DW'(32'h1234); CheckRd = AW'(5);
    #2;
    checks++; if (RfWe !== exp_we0) begin errors++; $display("FAIL lat_we_c1: got %0b want %0b", RfWe, exp_we0); end
    checks++; if (CheckHit !== 1'b0) begin errors++; $display("FAIL lat_hit_c1: got %0b want 0", CheckHit); end
    if (exp_we0) begin
      checks++; if (RfWd !== exp_wd) begin errors++; $display("FAIL lat_byp_wd: got %0h want %0h", RfWd, exp_wd); end
    end
    cyc();
    McValid = 1'b0;
    #2;
    checks++; if (RfWe !== exp_we1) begin errors++; $display("FAIL lat_we_c2: got %0b want %0b", RfWe, exp_we1); end
    checks++; if (CheckHit !== exp_hit1) begin errors++; $display("FAIL lat_hit_c2: got %0b want %0b", CheckHit, exp_hit1); end
    if (exp_we1) begin
      checks++; if (RfWa !== exp_wa) begin errors++; $display("FAIL lat_wa_c2: got %0d want %0d", RfWa, exp_wa); end
      checks++; if (RfWd !== exp_wd) begin errors++; $display("FAIL lat_wd_c2: got %0h want %0h", RfWd, exp_wd); end
    end
    cyc();
    #2;
    checks++; if (RfWe !== 1'b0)     begin errors++; $display("FAIL lat_we_c3: got %0b want 0", RfWe); end
    checks++; if (CheckHit !== 1'b0) begin errors++; $display("FAIL lat_hit_c3: got %0b want 0", CheckHit); end
    idle_in();
  endtask

  task automatic test_starve();
    RegWriteW = 1'b1; RdW = AW'(7); ResultW = DW'(32'h77); CheckRd = AW'(13);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      McValid = 1'b1; McRd = AW'(10 + i); McData = DW'(32'h100 + i);
      #2;
      checks++; if (McReady !== 1'b1) begin errors++; $display("FAIL st_ready_push%0d: got %0b want 1", i, McReady); end
      checks++; if (RfWa !== AW'(7))  begin errors++; $display("FAIL st_pipe_wa%0d: got %0d want 7", i, RfWa); end
    end
    cyc();
    McValid = 1'b0;
    #2;
    checks++; if (McReady !== 1'b0)  begin errors++; $display("FAIL st_ready_full: got %0b want 0", McReady); end
    checks++; if (CheckHit !== 1'b1) begin errors++; $display("FAIL st_hit13: got %0b want 1", CheckHit); end
    for (int c = 6; c <= 9; c++) begin
      cyc();
      #2;
      checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL st_stall_early_c%0d: got %0b want 0", c, StallReq); end
    end
    cyc();
    #2;
    checks++; if (StallReq !== 1'b1) begin errors++; $display("FAIL st_stall_on: got %0b want 1", StallReq); end
    cyc();
    #2;
    checks++; if (StallReq !== 1'b1) begin errors++; $display("FAIL st_stall_hold: got %0b want 1", StallReq); end
    checks++; if (RfWa !== AW'(7))   begin errors++; $display("FAIL st_pipe_wins: got %0d want 7", RfWa); end
    cyc();
    RegWriteW = 1'b0;
    #2;
    checks++; if (RfWe !== 1'b1 || RfWa !== AW'(11) || RfWd !== DW'(32'h101)) begin
      errors++; $display("FAIL st_bubble_pop: got we=%0b wa=%0d wd=%0h want 1/11/101", RfWe, RfWa, RfWd);
    end
    checks++; if (StallReq !== 1'b1) begin errors++; $display("FAIL st_stall_pop: got %0b want 1", StallReq); end
    for (int j = 0; j < 3; j++) begin
      cyc();
      #2;
      if (j == 0) begin
        checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL st_stall_drop: got %0b want 0", StallReq); end
        checks++; if (McReady !== 1'b1)  begin errors++; $display("FAIL st_ready_again: got %0b want 1", McReady); end
      end
      checks++; if (RfWe !== 1'b1 || RfWa !== AW'(12 + j) || RfWd !== DW'(32'h102 + j)) begin
        errors++; $display("FAIL st_drain%0d: got we=%0b wa=%0d wd=%0h want 1/%0d/%0h", j, RfWe, RfWa, RfWd, 12 + j, 32'h102 + j);
      end
    end
    cyc();
    #2;
    checks++; if (RfWe !== 1'b0) begin errors++; $display("FAIL st_empty_we: got %0b want 0", RfWe); end
    idle_in();
  endtask

  task automatic test_x0_slot();
    cyc();
    RegWriteW = 1'b1; RdW = AW'(7); ResultW = DW'(32'h77);
    McValid = 1'b1; McRd = AW'(3); McData = DW'(32'hAA);
    cyc();
    McValid = 1'b0; RdW = '0; ResultW = DW'(32'h55);
    #2;
    checks++; if (RfWe !== 1'b1 || RfWa !== AW'(3) || RfWd !== DW'(32'hAA)) begin
      errors++; $display("FAIL x0_fifo_write: got we=%0b wa=%0d wd=%0h want 1/3/aa", RfWe, RfWa, RfWd);
    end
    cyc();
    #2;
    checks++; if (RfWe !== 1'b0) begin errors++; $display("FAIL x0_discard: got %0b want 0", RfWe); end
    idle_in();
  endtask

  task automatic test_full_pop();
    RegWriteW = 1'b1; RdW = AW'(7); ResultW = DW'(32'h77);
    for (int i = 0; i < 4; i++) begin
      cyc();
      McValid = 1'b1; McRd = AW'(20 + i); McData = DW'(32'h200 + i);
    end
    cyc();
    RegWriteW = 1'b0; McValid = 1'b1; McRd = AW'(30); McData = DW'(32'h300);
    #2;
    checks++; if (McReady !== 1'b0)  begin errors++; $display("FAIL fp_ready_refuse: got %0b want 0", McReady); end
    checks++; if (RfWa !== AW'(20)) begin errors++; $display("FAIL fp_pop_head: got %0d want 20", RfWa); end
    cyc();
    McValid = 1'b0; RegWriteW = 1'b1;
    #2;
    checks++; if (McReady !== 1'b1) begin errors++; $display("FAIL fp_ready_after: got %0b want 1", McReady); end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      RegWriteW = 1'b0;
      #2;
      checks++; if (RfWe !== 1'b1 || RfWa !== AW'(20 + j)) begin
        errors++; $display("FAIL fp_drain%0d: got we=%0b wa=%0d want 1/%0d", j, RfWe, RfWa, 20 + j);
      end
    end
    cyc();
    #2;
    checks++; if (RfWe !== 1'b0) begin errors++; $display("FAIL fp_no_refused_write: got we=%0b wa=%0d want 0", RfWe, RfWa); end
    idle_in();
  endtask

  task automatic test_zero_rd();
    cyc();
    McValid = 1'b1; McRd = '0; McData = DW'(32'hDEAD); CheckRd = '0;
    #2;
    checks++; if (RfWe !== 1'b0 || CheckHit !== 1'b0) begin
      errors++; $display("FAIL z_push_c1: got we=%0b hit=%0b want 0/0", RfWe, CheckHit);
    end
    for (int c = 0; c < 2; c++) begin
      cyc();
      McValid = 1'b0;
      #2;
      checks++; if (RfWe !== 1'b0 || CheckHit !== 1'b0) begin
        errors++; $display("FAIL z_after_c%0d: got we=%0b hit=%0b want 0/0", c, RfWe, CheckHit);
      end
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    RegWriteW = 1'b1; RdW = AW'(7); ResultW = DW'(32'h77); CheckRd = AW'(25);
    for (int i = 0; i < 3; i++) begin
      cyc();
      McValid = 1'b1; McRd = AW'(24 + i); McData = DW'(32'h400 + i);
    end
    for (int c = 4; c <= 9; c++) begin
      cyc();
      McValid = 1'b0;
    end
    cyc();
    #2;
    checks++; if (StallReq !== 1'b1) begin errors++; $display("FAIL rm_stall_pre: got %0b want 1", StallReq); end
    rst = 1'b1;
    #1;
    checks++; if (RfWe !== 1'b0)     begin errors++; $display("FAIL rm_we: got %0b want 0", RfWe); end
    checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL rm_stall: got %0b want 0", StallReq); end
    checks++; if (McReady !== 1'b1)  begin errors++; $display("FAIL rm_ready: got %0b want 1", McReady); end
    checks++; if (CheckHit !== 1'b0) begin errors++; $display("FAIL rm_hit: got %0b want 0", CheckHit); end
    cyc();
    rst = 1'b0;
    RegWriteW = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (RfWe !== 1'b0) begin errors++; $display("FAIL rm_no_write_c%0d: got we=%0b wa=%0d want 0", c, RfWe, RfWa); end
      cyc();
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_starve();
    test_x0_slot();
    test_full_pop();
    test_zero_rd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
